// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
// Holds the decode bus layout, issue-mode encodings and the buffer entry format.
package inst_buffer_pkg;

    localparam int   IB_DEPTH     = 16;
    localparam int   IB_TO_ID_WD  = 130;
    localparam logic SINGLE_ISSUE = 1'b0;
    localparam logic DUAL_ISSUE   = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ib_entry_t;

    typedef struct packed {
        logic        inst2_valid;
        logic [31:0] inst2_pc;
        logic [31:0] inst2;
        logic        inst1_valid;
        logic [31:0] inst1_pc;
        logic [31:0] inst1;
    } ib_to_id_t;

endpackage

// File: rtl/inst_buffer_ib_ram.sv
// Entry storage for the instruction buffer: two write ports, two async read ports.
// Writes land on the clock edge; reads are combinational from the stored array.
// No flow control here; the write addresses are always distinct.
module ib_ram
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we0,
    input  logic [PTR_W-1:0] waddr0,
    input  ib_entry_t        wdat0,
    input  logic             we1,
    input  logic [PTR_W-1:0] waddr1,
    input  ib_entry_t        wdat1,
    input  logic [PTR_W-1:0] raddr0,
    input  logic [PTR_W-1:0] raddr1,
    output ib_entry_t        rdat0,
    output ib_entry_t        rdat1
);

    ib_entry_t mem_q [DEPTH];
    ib_entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we0) mem_d[waddr0] = wdat0;
        if (we1) mem_d[waddr1] = wdat1;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdat0 = mem_q[raddr0];
    assign rdat1 = mem_q[raddr1];

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch (2 per cycle) and dual-issue decode.
// Pushed entries are visible one cycle later; outputs are combinational from state.
// ib_full asserts below 2 free slots; a push arriving while full is dropped whole.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid1,
    input  logic [31:0]            in_pc1,
    input  logic [31:0]            in_inst1,
    input  logic                   in_valid2,
    input  logic [31:0]            in_pc2,
    input  logic [31:0]            in_inst2,
    input  logic                   launched,
    input  logic                   launch_mode,
    output logic [IB_TO_ID_WD-1:0] ib_to_id_bus,
    output logic                   ib_full,
    output logic [PTR_W:0]         ib_count
);

    localparam logic [PTR_W:0] FULL_THR = (PTR_W+1)'(DEPTH - 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [1:0]  push_n, push_acc, pop_req, pop_n;
    logic        full;
    logic        we0, we1;
    ib_entry_t   wdat0, wdat1, rdat0, rdat1;
    ib_to_id_t   bus;

    assign full = count_q >= FULL_THR;

    always_comb begin
        push_n   = {1'b0, in_valid1} + {1'b0, in_valid2};
        // Acceptance looks at pre-pop occupancy so fetch never has to see the pop.
        push_acc = full ? 2'd0 : push_n;
        pop_req  = !launched ? 2'd0 : ((launch_mode == DUAL_ISSUE) ? 2'd2 : 2'd1);
        pop_n    = ({{(PTR_W-1){1'b0}}, pop_req} > count_q) ? count_q[1:0] : pop_req;

        // Compact the valid slots so a slot-2-only push lands at tail.
        wdat0.pc   = in_valid1 ? in_pc1   : in_pc2;
        wdat0.inst = in_valid1 ? in_inst1 : in_inst2;
        wdat1.pc   = in_pc2;
        wdat1.inst = in_inst2;
        we0        = (push_acc != 2'd0) && !flush;
        we1        = (push_acc == 2'd2) && !flush;

        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q + PTR_W'(push_acc);
        count_d = count_q + (PTR_W+1)'(push_acc) - (PTR_W+1)'(pop_n);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    ib_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (tail_q),
        .wdat0  (wdat0),
        .we1    (we1),
        .waddr1 (tail_q + PTR_W'(1)),
        .wdat1  (wdat1),
        .raddr0 (head_q),
        .raddr1 (head_q + PTR_W'(1)),
        .rdat0  (rdat0),
        .rdat1  (rdat1)
    );

    always_comb begin
        bus             = '0;
        bus.inst1_valid = count_q != '0;
        bus.inst2_valid = count_q > (PTR_W+1)'(1);
        if (bus.inst1_valid) begin
            bus.inst1_pc = rdat0.pc;
            bus.inst1    = rdat0.inst;
        end
        if (bus.inst2_valid) begin
            bus.inst2_pc = rdat1.pc;
            bus.inst2    = rdat1.inst;
        end
    end

    assign ib_to_id_bus = bus;
    assign ib_full      = full;
    assign ib_count     = count_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed table plus hand sequences for fill/full, wrap-around, flush and reset.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid1, in_valid2, launched, launch_mode;
    logic [31:0]  in_pc1, in_inst1, in_pc2, in_inst2;
    logic [129:0] ib_to_id_bus;
    logic         ib_full;
    logic [4:0]   ib_count;

    always #5 clk = ~clk;

    inst_buffer #(.DEPTH(DEPTH), .PTR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid1    (in_valid1),
        .in_pc1       (in_pc1),
        .in_inst1     (in_inst1),
        .in_valid2    (in_valid2),
        .in_pc2       (in_pc2),
        .in_inst2     (in_inst2),
        .launched     (launched),
        .launch_mode  (launch_mode),
        .ib_to_id_bus (ib_to_id_bus),
        .ib_full      (ib_full),
        .ib_count     (ib_count)
    );

    typedef struct {
        bit          r, f, v1;
        logic [31:0] p1, i1;
        bit          v2;
        logic [31:0] p2, i2;
        bit          l, m;
        int          ecnt;
        bit          efull;
        logic [31:0] epc1, ei1, epc2, ei2;
    } vec_t;

    vec_t       tbl[$];
    ib_entry_t  mq[$];
    int         n_vec = 0;
    int         n_bad = 0;

    function automatic vec_t mk(bit r, bit f, bit v1, logic [31:0] p1, logic [31:0] i1,
                                bit v2, logic [31:0] p2, logic [31:0] i2, bit l, bit m,
                                int ecnt, bit efull, logic [31:0] epc1, logic [31:0] ei1,
                                logic [31:0] epc2, logic [31:0] ei2);
        vec_t v;
        v.r = r; v.f = f; v.v1 = v1; v.p1 = p1; v.i1 = i1;
        v.v2 = v2; v.p2 = p2; v.i2 = i2; v.l = l; v.m = m;
        v.ecnt = ecnt; v.efull = efull;
        v.epc1 = epc1; v.ei1 = ei1; v.epc2 = epc2; v.ei2 = ei2;
        return v;
    endfunction

    function automatic ib_entry_t mke(logic [31:0] pc, logic [31:0] inst);
        ib_entry_t e;
        e.pc   = pc;
        e.inst = inst;
        return e;
    endfunction

    function automatic logic [129:0] mk_bus(int cnt, logic [31:0] pc1, logic [31:0] i1,
                                            logic [31:0] pc2, logic [31:0] i2);
        logic b1, b2;
        b1 = (cnt >= 1);
        b2 = (cnt >= 2);
        return {b2, pc2, i2, b1, pc1, i1};
    endfunction

    task automatic compare(string name, int idx, logic [129:0] ebus, int ecnt, bit efull);
        n_vec++;
        if (ib_to_id_bus !== ebus || ib_count !== 5'(ecnt) || ib_full !== efull) begin
            n_bad++;
            $display("FAIL %s[%0d]: got count=%0d full=%0b bus=%h, want count=%0d full=%0b bus=%h",
                     name, idx, ib_count, ib_full, ib_to_id_bus, ecnt, efull, ebus);
        end
    endtask

    task automatic drive(bit r, bit f, bit v1, logic [31:0] p1, logic [31:0] i1,
                         bit v2, logic [31:0] p2, logic [31:0] i2, bit l, bit m);
        rst = r; flush = f;
        in_valid1 = v1; in_pc1 = p1; in_inst1 = i1;
        in_valid2 = v2; in_pc2 = p2; in_inst2 = i2;
        launched = l; launch_mode = m;
    endtask

    // Reference queue: pop from the front, push at the back, push judged on pre-pop size.
    task automatic model_step(bit r, bit f, bit v1, logic [31:0] p1, logic [31:0] i1,
                              bit v2, logic [31:0] p2, logic [31:0] i2, bit l, bit m);
        int sz, req, pop;
        bit mfull;
        sz    = mq.size();
        mfull = (DEPTH - sz) < 2;
        req   = l ? (m ? 2 : 1) : 0;
        pop   = (req < sz) ? req : sz;
        if (r || f) begin
            mq.delete();
        end else begin
            repeat (pop) void'(mq.pop_front());
            if (!mfull) begin
                if (v1) mq.push_back(mke(p1, i1));
                if (v2) mq.push_back(mke(p2, i2));
            end
        end
    endtask

    task automatic check_model(string name, int idx);
        int sz;
        logic [31:0] pc1, i1, pc2, i2;
        sz = mq.size();
        pc1 = 0; i1 = 0; pc2 = 0; i2 = 0;
        if (sz >= 1) begin pc1 = mq[0].pc; i1 = mq[0].inst; end
        if (sz >= 2) begin pc2 = mq[1].pc; i2 = mq[1].inst; end
        compare(name, idx, mk_bus(sz, pc1, i1, pc2, i2), sz, (DEPTH - sz) < 2);
    endtask

    task automatic step(string name, int idx, bit r, bit f, bit v1, logic [31:0] p1,
                        bit v2, logic [31:0] p2, bit l, bit m);
        logic [31:0] i1, i2;
        i1 = v1 ? ~p1 : 32'h0;
        i2 = v2 ? ~p2 : 32'h0;
        drive(r, f, v1, p1, i1, v2, p2, i2, l, m);
        @(posedge clk);
        model_step(r, f, v1, p1, i1, v2, p2, i2, l, m);
        #1;
        check_model(name, idx);
    endtask

    initial begin
        int idx;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl.push_back(mk(1,0, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0));
        tbl.push_back(mk(0,0, 1,32'hBFC00000,32'h24010001, 1,32'hBFC00004,32'h24020002, 0,0,
                         2,0, 32'hBFC00000,32'h24010001,32'hBFC00004,32'h24020002));
        tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 1,1, 0,0, 0,0,0,0));
        tbl.push_back(mk(0,0, 1,32'h100,32'h11, 1,32'h104,32'h12, 0,0, 2,0, 32'h100,32'h11,32'h104,32'h12));
        tbl.push_back(mk(0,0, 1,32'h108,32'h13, 0,0,0, 0,0, 3,0, 32'h100,32'h11,32'h104,32'h12));
        tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 1,0, 2,0, 32'h104,32'h12,32'h108,32'h13));
        tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 1,0, 1,0, 32'h108,32'h13,0,0));
        tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 1,1, 0,0, 0,0,0,0));
        tbl.push_back(mk(0,0, 0,0,0, 1,32'h200,32'h21, 1,1, 1,0, 32'h200,32'h21,0,0));
        tbl.push_back(mk(0,0, 1,32'h204,32'h22, 1,32'h208,32'h23, 1,0, 2,0, 32'h204,32'h22,32'h208,32'h23));
        tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,1, 2,0, 32'h204,32'h22,32'h208,32'h23));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].f, tbl[i].v1, tbl[i].p1, tbl[i].i1,
                  tbl[i].v2, tbl[i].p2, tbl[i].i2, tbl[i].l, tbl[i].m);
            @(posedge clk);
            #1;
            compare("tbl", i, mk_bus(tbl[i].ecnt, tbl[i].epc1, tbl[i].ei1, tbl[i].epc2, tbl[i].ei2),
                    tbl[i].ecnt, tbl[i].efull);
        end

        mq.push_back(mke(32'h204, 32'h22));
        mq.push_back(mke(32'h208, 32'h23));

        // Fill to 15, drop a push while full, refill to 16, then drain across the wrap.
        for (int k = 0; k < 6; k++)
            step("fill", k, 0, 0, 1, 32'h300 + 8*k, 1, 32'h304 + 8*k, 0, 0);
        step("fill15", 0, 0, 0, 1, 32'h330, 0, 0, 0, 0);
        step("full_drop", 0, 0, 0, 1, 32'h334, 1, 32'h338, 1, 0);
        step("refill16", 0, 0, 0, 1, 32'h334, 1, 32'h338, 0, 0);
        step("drop_at16", 0, 0, 0, 1, 32'h33c, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++)
            step("drain", k, 0, 0, 0, 0, 0, 0, 1, 1);

        idx = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit a1, a2, l, m;
            logic [31:0] q1, q2;
            int acc;
            if (idx >= 40 && mq.size() == 0) break;
            a1  = (idx < 40) && ($urandom_range(0, 1) == 1);
            a2  = ((idx + int'(a1)) < 40) && ($urandom_range(0, 1) == 1);
            q1  = a1 ? 32'h1000 + 4*idx : 32'h0;
            q2  = a2 ? 32'h1000 + 4*(idx + int'(a1)) : 32'h0;
            l   = (idx >= 40) || ($urandom_range(0, 2) != 0);
            m   = $urandom_range(0, 1) == 1;
            acc = ((DEPTH - mq.size()) < 2) ? 0 : int'(a1) + int'(a2);
            step("stream", cyc, 0, 0, a1, q1, a2, q2, l, m);
            idx += acc;
        end
        n_vec++;
        if (idx < 40 || mq.size() != 0) begin
            n_bad++;
            $display("FAIL stream_done: pushed %0d of 40, %0d still queued, want 40 and 0",
                     idx, mq.size());
        end

        for (int k = 0; k < 3; k++)
            step("pre_flush", k, 0, 0, 1, 32'h2000 + 8*k, 1, 32'h2004 + 8*k, 0, 0);
        step("flush", 0, 0, 1, 1, 32'h2100, 1, 32'h2104, 1, 1);
        step("post_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("pre_rst", 0, 0, 0, 1, 32'h3000, 1, 32'h3004, 0, 0);
        step("pre_rst", 1, 0, 0, 1, 32'h3008, 1, 32'h300c, 0, 0);
        step("pre_rst", 2, 0, 0, 1, 32'h3010, 0, 0, 0, 0);
        step("mid_rst", 0, 1, 0, 1, 32'h3100, 1, 32'h3104, 1, 1);
        step("post_rst", 0, 0, 0, 1, 32'h3200, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
